// File: rtl/aes_arbiter_if.sv
// Signal bundle between two block requesters, the shared AES engine and the arbiter.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface aes_arbiter_if;
  logic         r0_valid, r0_ready, r1_valid, r1_ready;
  logic [127:0] r0_block, r0_ctr, r1_block, r1_ctr;
  logic [255:0] r0_key, r1_key;
  logic         r0_out_valid, r0_out_ready, r1_out_valid, r1_out_ready;
  logic [127:0] r0_out_block, r1_out_block;
  logic         aes_in_valid, aes_in_ready;
  logic [127:0] aes_in_block, aes_ctr;
  logic [255:0] aes_key;
  logic         aes_out_valid, aes_out_ready;
  logic [127:0] aes_out_block;
  logic         aes_fifo_empty;

  modport slave (
    input  r0_valid, r0_block, r0_ctr, r0_key, r0_out_ready,
    input  r1_valid, r1_block, r1_ctr, r1_key, r1_out_ready,
    input  aes_in_ready, aes_out_valid, aes_out_block, aes_fifo_empty,
    output r0_ready, r0_out_valid, r0_out_block,
    output r1_ready, r1_out_valid, r1_out_block,
    output aes_in_valid, aes_in_block, aes_ctr, aes_key, aes_out_ready
  );

  modport master (
    output r0_valid, r0_block, r0_ctr, r0_key, r0_out_ready,
    output r1_valid, r1_block, r1_ctr, r1_key, r1_out_ready,
    output aes_in_ready, aes_out_valid, aes_out_block, aes_fifo_empty,
    input  r0_ready, r0_out_valid, r0_out_block,
    input  r1_ready, r1_out_valid, r1_out_block,
    input  aes_in_valid, aes_in_block, aes_ctr, aes_key, aes_out_ready
  );
endinterface

// File: rtl/aes_arbiter.sv
// Two-requester arbiter for a shared pipelined AES engine: bursty round-robin grant,
// outstanding-block tracking, and a drain phase so the key never changes under in-flight blocks.
module aes_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int OUT_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  aes_arbiter_if.slave   bus,
  output logic           owner
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int              BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [OUT_W-1:0] OUT_MAX   = '1;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;

  logic in_own, active, own_valid, other_valid, limit_ok, issue, ret;

  assign in_own      = (state_q == S_OWN);
  assign active      = in_own || (state_q == S_DRAIN);
  assign own_valid   = owner_q ? bus.r1_valid : bus.r0_valid;
  assign other_valid = owner_q ? bus.r0_valid : bus.r1_valid;
  assign limit_ok    = (outstanding_q != OUT_MAX);

  assign bus.aes_in_valid = in_own && own_valid && limit_ok;
  assign bus.r0_ready     = in_own && !owner_q && bus.aes_in_ready && limit_ok;
  assign bus.r1_ready     = in_own &&  owner_q && bus.aes_in_ready && limit_ok;

  // Owner only moves in IDLE, so this mux is stable for every block in flight.
  assign bus.aes_in_block = owner_q ? bus.r1_block : bus.r0_block;
  assign bus.aes_ctr      = owner_q ? bus.r1_ctr   : bus.r0_ctr;
  assign bus.aes_key      = owner_q ? bus.r1_key   : bus.r0_key;

  assign bus.aes_out_ready = active && (owner_q ? bus.r1_out_ready : bus.r0_out_ready);
  assign bus.r0_out_valid  = active && !owner_q && bus.aes_out_valid;
  assign bus.r1_out_valid  = active &&  owner_q && bus.aes_out_valid;
  assign bus.r0_out_block  = (active && !owner_q) ? bus.aes_out_block : '0;
  assign bus.r1_out_block  = (active &&  owner_q) ? bus.aes_out_block : '0;

  assign issue = bus.aes_in_valid && bus.aes_in_ready;
  assign ret   = bus.aes_out_valid && bus.aes_out_ready;
  assign owner = owner_q;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    burst_d       = burst_q;
    outstanding_d = outstanding_q;

    if (issue && !ret)
      outstanding_d = outstanding_q + OUT_W'(1);
    else if (ret && !issue && outstanding_q != '0)
      outstanding_d = outstanding_q - OUT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.r0_valid || bus.r1_valid) begin
          owner_d = (bus.r0_valid && bus.r1_valid) ? rr_q : bus.r1_valid;
          burst_d = '0;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (issue && burst_q != BURST_LAST)
          burst_d = burst_q + BW'(1);
        // Yield only when the other side is actually waiting.
        if (other_valid && ((issue && burst_q == BURST_LAST) || !own_valid))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outstanding_q == '0 && bus.aes_fifo_empty) begin
          state_d = S_IDLE;
          rr_d    = ~owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b0;
      rr_q          <= 1'b0;
      burst_q       <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      burst_q       <= burst_d;
      outstanding_q <= outstanding_d;
    end
  end
endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter: single requester, burst handover, valid drop,
// outstanding limit, and asynchronous reset during drain.
module tb_aes_arbiter;
  localparam logic [1:0] IDLE = 2'd0, OWN = 2'd1, DRAIN = 2'd2;
  localparam logic [255:0] KEY0 = {8{32'hA0A0_0001}};
  localparam logic [255:0] KEY1 = {8{32'hB1B1_0002}};

  logic clk, rst, owner;
  int   n_tests, n_fail;

  aes_arbiter_if bus ();

  aes_arbiter #(.MAX_BURST(16), .OUT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.r0_valid = 0; bus.r1_valid = 0;
    bus.r0_block = 128'h0; bus.r1_block = 128'h0;
    bus.r0_ctr = 128'h100; bus.r1_ctr = 128'h200;
    bus.r0_key = KEY0; bus.r1_key = KEY1;
    bus.r0_out_ready = 0; bus.r1_out_ready = 0;
    bus.aes_in_ready = 0; bus.aes_out_valid = 0;
    bus.aes_out_block = 128'h0; bus.aes_fifo_empty = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.r0_valid = 1; bus.aes_in_ready = 1; bus.aes_out_valid = 1; bus.r0_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
    n_tests++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b want 0", owner); end
    n_tests++; if (dut.outstanding_q !== 8'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", dut.outstanding_q); end
    n_tests++; if ({bus.aes_in_valid, bus.r0_ready, bus.r1_ready, bus.aes_out_ready, bus.r0_out_valid, bus.r1_out_valid} !== 6'b0)
      begin n_fail++; $display("FAIL reset_outputs: got %b want 000000", {bus.aes_in_valid, bus.r0_ready, bus.r1_ready, bus.aes_out_ready, bus.r0_out_valid, bus.r1_out_valid}); end
    n_tests++; if (bus.aes_key !== KEY0) begin n_fail++; $display("FAIL reset_key_mux: got %h want %h", bus.aes_key, KEY0); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.r0_valid = 1; bus.aes_in_ready = 1;
    #1;
    n_tests++; if (bus.r0_ready !== 1'b0) begin n_fail++; $display("FAIL single_idle_ready: got %b want 0", bus.r0_ready); end
    cyc();
    n_tests++; if (dut.state_q !== OWN || owner !== 1'b0) begin n_fail++; $display("FAIL single_grant: state %0d owner %b want 1/0", dut.state_q, owner); end
    for (int i = 0; i < 4; i++) begin
      bus.r0_block = 128'h1000 + 128'(i);
      #1;
      n_tests++; if (bus.aes_in_valid !== 1'b1 || bus.r0_ready !== 1'b1 || bus.aes_in_block !== 128'h1000 + 128'(i))
        begin n_fail++; $display("FAIL single_issue[%0d]: valid %b ready %b block %h", i, bus.aes_in_valid, bus.r0_ready, bus.aes_in_block); end
      cyc();
    end
    bus.r0_valid = 0;
    n_tests++; if (dut.outstanding_q !== 8'd4) begin n_fail++; $display("FAIL single_outstanding4: got %0d want 4", dut.outstanding_q); end
    bus.aes_out_valid = 1; bus.r0_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus.aes_out_block = 128'hC000 + 128'(i);
      #1;
      n_tests++; if (bus.r0_out_valid !== 1'b1 || bus.r1_out_valid !== 1'b0 || bus.aes_out_ready !== 1'b1 || bus.r0_out_block !== 128'hC000 + 128'(i))
        begin n_fail++; $display("FAIL single_result[%0d]: r0v %b r1v %b rdy %b blk %h", i, bus.r0_out_valid, bus.r1_out_valid, bus.aes_out_ready, bus.r0_out_block); end
      cyc();
    end
    n_tests++; if (dut.outstanding_q !== 8'd0) begin n_fail++; $display("FAIL single_outstanding0: got %0d want 0", dut.outstanding_q); end
    cyc();
    n_tests++; if (dut.outstanding_q !== 8'd0) begin n_fail++; $display("FAIL single_underflow: got %0d want 0", dut.outstanding_q); end
    n_tests++; if (dut.state_q !== OWN || owner !== 1'b0) begin n_fail++; $display("FAIL single_retain: state %0d owner %b want 1/0", dut.state_q, owner); end
    bus.aes_out_valid = 0;
  endtask

  task automatic test_burst_handover();
    do_reset();
    bus.r0_valid = 1; bus.r1_valid = 1; bus.aes_in_ready = 1;
    cyc();
    n_tests++; if (owner !== 1'b0) begin n_fail++; $display("FAIL burst_first_owner: got %b want 0", owner); end
    for (int i = 0; i < 16; i++) begin
      #1;
      n_tests++; if (bus.aes_in_valid !== 1'b1 || bus.aes_key !== KEY0)
        begin n_fail++; $display("FAIL burst_issue[%0d]: valid %b key %h", i, bus.aes_in_valid, bus.aes_key); end
      cyc();
    end
    n_tests++; if (dut.state_q !== DRAIN || dut.outstanding_q !== 8'd16)
      begin n_fail++; $display("FAIL burst_drain: state %0d outst %0d want 2/16", dut.state_q, dut.outstanding_q); end
    n_tests++; if (bus.aes_in_valid !== 1'b0 || bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0)
      begin n_fail++; $display("FAIL burst_no_issue: valid %b r0r %b r1r %b want 000", bus.aes_in_valid, bus.r0_ready, bus.r1_ready); end
    bus.aes_out_valid = 1; bus.r0_out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_tests++; if (bus.r0_out_valid !== 1'b1 || bus.aes_key !== KEY0)
        begin n_fail++; $display("FAIL burst_return[%0d]: r0v %b key %h", i, bus.r0_out_valid, bus.aes_key); end
      cyc();
    end
    bus.aes_out_valid = 0;
    cyc();
    n_tests++; if (dut.state_q !== DRAIN || bus.aes_key !== KEY0)
      begin n_fail++; $display("FAIL burst_wait_fifo: state %0d key %h want DRAIN/key0", dut.state_q, bus.aes_key); end
    bus.aes_fifo_empty = 1;
    cyc();
    n_tests++; if (dut.state_q !== IDLE || bus.aes_key !== KEY0 || bus.aes_in_valid !== 1'b0)
      begin n_fail++; $display("FAIL burst_idle: state %0d key %h valid %b", dut.state_q, bus.aes_key, bus.aes_in_valid); end
    cyc();
    n_tests++; if (owner !== 1'b1 || bus.aes_key !== KEY1 || bus.r1_ready !== 1'b1 || bus.r0_ready !== 1'b0)
      begin n_fail++; $display("FAIL burst_r1_grant: owner %b key %h r1r %b r0r %b", owner, bus.aes_key, bus.r1_ready, bus.r0_ready); end
  endtask

  task automatic test_drop_valid();
    do_reset();
    bus.r0_valid = 1; bus.aes_in_ready = 1;
    cyc();
    cyc(); cyc();
    bus.r0_valid = 0; bus.r1_valid = 1;
    #1;
    n_tests++; if (dut.state_q !== OWN || bus.aes_in_valid !== 1'b0)
      begin n_fail++; $display("FAIL drop_still_own: state %0d valid %b want 1/0", dut.state_q, bus.aes_in_valid); end
    cyc();
    bus.r0_valid = 1;
    #1;
    n_tests++; if (dut.state_q !== DRAIN || bus.r0_ready !== 1'b0 || bus.aes_in_valid !== 1'b0)
      begin n_fail++; $display("FAIL drop_drain: state %0d r0r %b valid %b", dut.state_q, bus.r0_ready, bus.aes_in_valid); end
    bus.aes_out_valid = 1; bus.r0_out_ready = 1; bus.r1_out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      bus.aes_out_block = 128'hD00 + 128'(i);
      #1;
      n_tests++; if (bus.r0_out_valid !== 1'b1 || bus.r1_out_valid !== 1'b0 || bus.r0_out_block !== 128'hD00 + 128'(i))
        begin n_fail++; $display("FAIL drop_result[%0d]: r0v %b r1v %b blk %h", i, bus.r0_out_valid, bus.r1_out_valid, bus.r0_out_block); end
      cyc();
    end
    bus.aes_out_valid = 0; bus.aes_fifo_empty = 1;
    cyc();
    cyc();
    n_tests++; if (dut.state_q !== OWN || owner !== 1'b1)
      begin n_fail++; $display("FAIL drop_rr_grant: state %0d owner %b want 1/1", dut.state_q, owner); end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    bus.r0_valid = 1; bus.aes_in_ready = 1; bus.aes_fifo_empty = 1;
    cyc();
    cyc(); cyc(); cyc();
    n_tests++; if (dut.outstanding_q !== 8'd3) begin n_fail++; $display("FAIL limit_three: got %0d want 3", dut.outstanding_q); end
    bus.aes_out_valid = 1; bus.r0_out_ready = 1;
    #1;
    n_tests++; if (bus.aes_in_valid !== 1'b1 || bus.aes_out_ready !== 1'b1)
      begin n_fail++; $display("FAIL limit_both: inv %b outr %b want 1/1", bus.aes_in_valid, bus.aes_out_ready); end
    cyc();
    bus.aes_out_valid = 0;
    n_tests++; if (dut.outstanding_q !== 8'd3) begin n_fail++; $display("FAIL limit_simul: got %0d want 3", dut.outstanding_q); end
    repeat (252) cyc();
    n_tests++; if (dut.outstanding_q !== 8'd255 || bus.aes_in_valid !== 1'b0 || bus.r0_ready !== 1'b0)
      begin n_fail++; $display("FAIL limit_full: outst %0d inv %b r0r %b want 255/0/0", dut.outstanding_q, bus.aes_in_valid, bus.r0_ready); end
    cyc();
    n_tests++; if (dut.outstanding_q !== 8'd255) begin n_fail++; $display("FAIL limit_hold: got %0d want 255", dut.outstanding_q); end
    bus.aes_out_valid = 1;
    #1;
    n_tests++; if (bus.aes_in_valid !== 1'b0) begin n_fail++; $display("FAIL limit_return_cycle: inv %b want 0", bus.aes_in_valid); end
    cyc();
    bus.aes_out_valid = 0;
    #1;
    n_tests++; if (dut.outstanding_q !== 8'd254 || bus.aes_in_valid !== 1'b1 || bus.r0_ready !== 1'b1)
      begin n_fail++; $display("FAIL limit_reopen: outst %0d inv %b r0r %b want 254/1/1", dut.outstanding_q, bus.aes_in_valid, bus.r0_ready); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    bus.r0_valid = 1; bus.r1_valid = 1; bus.aes_in_ready = 1;
    cyc();
    repeat (5) cyc();
    bus.r0_valid = 0;
    cyc();
    n_tests++; if (dut.state_q !== DRAIN || dut.outstanding_q !== 8'd5)
      begin n_fail++; $display("FAIL rstdrain_setup: state %0d outst %0d want 2/5", dut.state_q, dut.outstanding_q); end
    bus.r0_valid = 1; bus.aes_out_valid = 1; bus.r0_out_ready = 1;
    #1;
    n_tests++; if (bus.r0_out_valid !== 1'b1) begin n_fail++; $display("FAIL rstdrain_pre: r0v %b want 1", bus.r0_out_valid); end
    rst = 1'b1;
    #1;
    n_tests++; if (dut.state_q !== IDLE || dut.outstanding_q !== 8'd0 || owner !== 1'b0)
      begin n_fail++; $display("FAIL rstdrain_state: state %0d outst %0d owner %b", dut.state_q, dut.outstanding_q, owner); end
    n_tests++; if ({bus.aes_in_valid, bus.r0_ready, bus.r1_ready, bus.aes_out_ready, bus.r0_out_valid, bus.r1_out_valid} !== 6'b0)
      begin n_fail++; $display("FAIL rstdrain_outputs: got %b want 000000", {bus.aes_in_valid, bus.r0_ready, bus.r1_ready, bus.aes_out_ready, bus.r0_out_valid, bus.r1_out_valid}); end
    cyc();
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_burst_handover();
    test_drop_valid();
    test_outstanding_limit();
    test_reset_in_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
